// File: rtl/shift_pkg.sv
// Shared types for the multi-cycle shift unit.
// Mode and FSM state encodings used by shift_step and shift_seq_unit.
package shift_pkg;

  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    SRA = 2'b10,
    ROL = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } shift_state_t;

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

endpackage

// File: rtl/shift_step.sv
// One combinational shift step of 0..STEP positions.
// Rotate path exists only when SHIFT_ROTATE_EN is defined; otherwise ROL acts as SLL.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int AW    = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] value,
  input  logic [AW-1:0]    amt,
  input  shift_mode_t      mode,
  input  logic             sign,
  output logic [WIDTH-1:0] shifted
);

  logic [WIDTH-1:0] ones;
  logic [WIDTH-1:0] fill;

  always_comb begin
    ones    = '1;
    // SRA fill: vacated top bits take the captured sign
    fill    = sign ? ~(ones >> amt) : '0;
    shifted = value << amt;
    unique case (mode)
      SRL: shifted = value >> amt;
      SRA: shifted = (value >> amt) | fill;
`ifdef SHIFT_ROTATE_EN
      ROL: shifted = (value << amt)
                   | (value >> (WIDTH - int'(amt)));
`endif
      default: shifted = value << amt;
    endcase
  end

endmodule

// File: rtl/shift_seq_unit.sv
// Multi-cycle variable shifter with valid/ready on both sides.
// Optional rotate mode via SHIFT_ROTATE_EN.
module shift_seq_unit
  import shift_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int STEP  = 2,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data_operand,
  input  logic [SHW-1:0]   shamt,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result
);

  localparam int AW = $clog2(STEP + 1);

  shift_state_t     state_q;
  shift_state_t     state_d;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] stepped;
  shift_mode_t      mode_q;
  logic             sign_q;
  logic [SHW-1:0]   rem_q;
  logic [AW-1:0]    k;
  logic             last;

  always_comb begin
    last = 32'(rem_q) <= STEP;
    k    = last ? AW'(rem_q) : AW'(STEP);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP),
    .AW    (AW)
  ) u_step (
    .value   (work_q),
    .amt     (k),
    .mode    (mode_q),
    .sign    (sign_q),
    .shifted (stepped)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = SHIFT;
      end
      SHIFT: begin
        if (last) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      work_q <= '0;
      mode_q <= SLL;
      sign_q <= 1'b0;
      rem_q  <= '0;
    end else if (state_q == IDLE && in_valid) begin
      work_q <= data_operand;
      mode_q <= shift_mode_t'(mode);
      sign_q <= data_operand[WIDTH-1];
      rem_q  <= shamt;
    end else if (state_q == SHIFT) begin
      work_q <= stepped;
      rem_q  <= rem_q - SHW'(k);
    end
  end

  assign result = work_q;

endmodule

// File: tb/tb_shift_seq_unit.sv
// Self-checking bench for shift_seq_unit: directed cases plus
// random requests against an arithmetic reference model.
module tb_shift_seq_unit;

  localparam int WIDTH = 32;
  localparam int STEP  = 2;
  localparam int SHW   = 5;

  logic             clock = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] data_operand;
  logic [SHW-1:0]   shamt;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;

  int n_checks = 0;
  int n_pass   = 0;

  shift_seq_unit #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .data_operand (data_operand),
    .shamt        (shamt),
    .mode         (mode),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .result       (result)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model(input logic [31:0] op,
                                        input int s,
                                        input logic [1:0] md);
    logic [31:0] r;
    case (md)
      2'd1: r = op >> s;
      2'd2: r = 32'($signed(op) >>> s);
`ifdef SHIFT_ROTATE_EN
      2'd3: r = (s == 0) ? op : ((op << s) | (op >> (32 - s)));
`endif
      default: r = op << s;
    endcase
    return r;
  endfunction

  function automatic int lat(input int s);
    return (s == 0) ? 1 : (s + STEP - 1) / STEP;
  endfunction

  task automatic issue(input logic [31:0] op,
                       input int sh,
                       input logic [1:0] md);
    data_operand = op;
    shamt        = SHW'(sh);
    mode         = md;
    in_valid     = 1'b1;
    check("accept_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid     = 1'b0;
    data_operand = $urandom;
    shamt        = SHW'($urandom);
    mode         = 2'($urandom);
    check("busy_ready", in_ready, 0);
  endtask

  task automatic wait_done(input string tag,
                           input logic [31:0] exp,
                           input int exp_n,
                           input int hold);
    int c;
    c = 0;
    do begin
      @(posedge clock); #1;
      c++;
    end while (!out_valid && c < 100);
    check({tag, "_latency"}, c, exp_n);
    check({tag, "_result"}, result, exp);
    check({tag, "_done_ready"}, in_ready, 0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      check({tag, "_hold_valid"}, out_valid, 1);
      check({tag, "_hold_result"}, result, exp);
      check({tag, "_hold_ready"}, in_ready, 0);
    end
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check({tag, "_rel_valid"}, out_valid, 0);
    check({tag, "_rel_ready"}, in_ready, 1);
  endtask

  initial begin
    logic [31:0] op;
    logic [31:0] rol_exp;
    int          sh;
    logic [1:0]  md;
    int          hold;
    logic        seen;

    reset        = 1'b1;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    data_operand = '0;
    shamt        = '0;
    mode         = 2'd0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_result", result, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    issue(32'h0000_0001, 5, 2'd0);
    wait_done("sll5", 32'h0000_0020, 3, 0);
    release_out("sll5");

    issue(32'h8000_00F0, 4, 2'd2);
    wait_done("sra4", 32'hF800_000F, 2, 0);
    release_out("sra4");

    issue(32'h8000_00F0, 4, 2'd1);
    wait_done("srl4", 32'h0800_000F, 2, 0);
    release_out("srl4");

    issue(32'hDEAD_BEEF, 0, 2'd1);
    wait_done("shamt0", 32'hDEAD_BEEF, 1, 0);
    release_out("shamt0");

    issue(32'h8000_0000, 31, 2'd2);
    wait_done("sra31", 32'hFFFF_FFFF, 16, 0);
    release_out("sra31");

    issue(32'h1234_5678, 3, 2'd0);
    wait_done("bp", 32'h91A2_B3C0, 2, 5);

    data_operand = 32'h0000_00FF;
    shamt        = SHW'(8);
    mode         = 2'd0;
    in_valid     = 1'b1;
    out_ready    = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    check("ovl_idle_ready", in_ready, 1);
    check("ovl_idle_valid", out_valid, 0);
    @(posedge clock); #1;
    in_valid = 1'b0;
    check("ovl_accepted", in_ready, 0);
    wait_done("ovl", 32'h0000_FF00, 4, 0);
    release_out("ovl");

`ifdef SHIFT_ROTATE_EN
    rol_exp = 32'h0000_0003;
`else
    rol_exp = 32'h0000_0002;
`endif
    issue(32'h8000_0001, 1, 2'd3);
    wait_done("rol1", rol_exp, 1, 0);
    release_out("rol1");

    for (int i = 0; i < 40; i++) begin
      op   = $urandom;
      sh   = int'($urandom_range(0, WIDTH - 1));
      md   = 2'($urandom);
      hold = int'($urandom_range(0, 2));
      issue(op, sh, md);
      wait_done("rand", model(op, sh, md), lat(sh), hold);
      release_out("rand");
    end

    issue(32'hA5A5_A5A5, 6, 2'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    check("abort_result", result, 0);
    #2;
    reset = 1'b0;
    seen  = 1'b0;
    repeat (8) begin
      @(posedge clock); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort_no_valid", seen, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
